// File: rtl/sdp_be_write_merger_if.sv
// Byte-masked write request stream feeding the write merger.
// The producer drives valid/addr/data/byte-enables and the merger returns ready.
interface sdp_be_write_merger_if #(
  parameter int WABITS    = 10,
  parameter int NBYTES    = 4,
  parameter int BYTEWIDTH = 8
);
  localparam int WDBITS = NBYTES * BYTEWIDTH;

  logic              s_valid;
  logic              s_ready;
  logic [WABITS-1:0] s_addr;
  logic [WDBITS-1:0] s_data;
  logic [NBYTES-1:0] s_be;

  modport master (output s_valid, s_addr, s_data, s_be, input s_ready);
  modport slave  (input s_valid, s_addr, s_data, s_be, output s_ready);
endinterface

// File: rtl/sdp_be_write_merger.sv
// Write-side front end for a simple-dual-port byte-enable BRAM.
// Consecutive partial writes to one word are coalesced in a single pending
// entry. The entry is written out as one merged RAM write when one of three
// things happens: a different address arrives, flush is asserted, or the
// entry has sat idle for MAX_HOLD cycles. The pend_* outputs let a read port
// patch stale bytes for the word that is still held here.
module sdp_be_write_merger #(
  parameter int WABITS    = 10,
  parameter int NBYTES    = 4,
  parameter int BYTEWIDTH = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  sdp_be_write_merger_if.slave          s,
  input  logic                          flush,
  input  logic [WABITS-1:0]             ra,
  output logic                          we,
  output logic [WABITS-1:0]             wa,
  output logic [NBYTES*BYTEWIDTH-1:0]   wd,
  output logic [NBYTES-1:0]             be,
  output logic                          pend_hit,
  output logic [NBYTES-1:0]             pend_be,
  output logic [NBYTES*BYTEWIDTH-1:0]   pend_data,
  output logic                          busy
);
  localparam int WDBITS = NBYTES * BYTEWIDTH;
  localparam int CNT_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {ST_EMPTY, ST_HELD} state_t;

  state_t            state, state_nxt;
  logic [WABITS-1:0] p_addr, p_addr_nxt;
  logic [WDBITS-1:0] p_data, p_data_nxt;
  logic [NBYTES-1:0] p_be,   p_be_nxt;
  logic [CNT_W-1:0]  cnt,    cnt_nxt;

  logic              accept;
  logic              same_addr;
  logic [WDBITS-1:0] merged_data;
  logic              evict;
  logic [WABITS-1:0] ev_addr;
  logic [WDBITS-1:0] ev_data;
  logic [NBYTES-1:0] ev_be;

  // There is no backpressure: every request is taken outside reset.
  assign s.s_ready = ~rst;

  // An all-zero byte mask carries no data, so it is treated as if nothing arrived.
  assign accept    = s.s_valid && s.s_ready && (s.s_be != '0);
  assign same_addr = (s.s_addr == p_addr);

  assign busy      = (state == ST_HELD);
  assign pend_hit  = busy && (ra == p_addr);
  assign pend_be   = pend_hit ? p_be : '0;
  assign pend_data = p_data;

  // Overlay the incoming enabled lanes on top of the pending word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    merged_data = p_data;
    for (int i = 0; i < NBYTES; i++) begin
      if (s.s_be[i]) merged_data[i*BYTEWIDTH +: BYTEWIDTH] = s.s_data[i*BYTEWIDTH +: BYTEWIDTH];
    end
  end

  // Next-state logic: decides load / merge / evict for the pending entry.
  always_comb begin
    state_nxt  = state;
    p_addr_nxt = p_addr;
    p_data_nxt = p_data;
    p_be_nxt   = p_be;
    cnt_nxt    = cnt;
    evict      = 1'b0;
    ev_addr    = p_addr;
    ev_data    = p_data;
    ev_be      = p_be;

    case (state)
      ST_EMPTY: begin
        // A flush with nothing held is ignored.
        if (accept) begin
          p_addr_nxt = s.s_addr;
          p_data_nxt = s.s_data;
          p_be_nxt   = s.s_be;
          cnt_nxt    = '0;
          state_nxt  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (accept && same_addr) begin
          p_data_nxt = merged_data;
          p_be_nxt   = p_be | s.s_be;
          cnt_nxt    = '0;
          if (flush) begin
            // Merge first, then write out the combined word.
            evict     = 1'b1;
            ev_data   = merged_data;
            ev_be     = p_be | s.s_be;
            state_nxt = ST_EMPTY;
          end
        end else if (accept) begin
          // A different address displaces the old entry. Any flush applies to the old entry only.
          evict      = 1'b1;
          p_addr_nxt = s.s_addr;
          p_data_nxt = s.s_data;
          p_be_nxt   = s.s_be;
          cnt_nxt    = '0;
        end else if (flush) begin
          evict     = 1'b1;
          state_nxt = ST_EMPTY;
        end else if (cnt == CNT_LAST) begin
          evict     = 1'b1;
          state_nxt = ST_EMPTY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State and pending-entry registers, plus the registered RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the pending entry is a handful of flops rather than a memory array, so it is cleared on reset together with the state.
    if (rst) begin
      state  <= ST_EMPTY;
      p_addr <= '0;
      p_data <= '0;
      p_be   <= '0;
      cnt    <= '0;
      we     <= 1'b0;
      wa     <= '0;
      wd     <= '0;
      be     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      state  <= state_nxt;
      p_addr <= p_addr_nxt;
      p_data <= p_data_nxt;
      p_be   <= p_be_nxt;
      cnt    <= cnt_nxt;
      we     <= evict;
      if (evict) begin
        wa <= ev_addr;
        wd <= ev_data;
        be <= ev_be;
      end
    end
  end
endmodule

// File: tb/tb_sdp_be_write_merger.sv
// Self-checking bench for sdp_be_write_merger: directed scenarios plus a
// randomized run checked against a word-level memory reference.
module tb_sdp_be_write_merger;
  localparam int WABITS    = 10;
  localparam int NBYTES    = 4;
  localparam int BYTEWIDTH = 8;
  localparam int WDBITS    = NBYTES * BYTEWIDTH;
  localparam int MAX_HOLD  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [WABITS-1:0] ra;
  logic              we;
  logic [WABITS-1:0] wa;
  logic [WDBITS-1:0] wd;
  logic [NBYTES-1:0] be;
  logic              pend_hit;
  logic [NBYTES-1:0] pend_be;
  logic [WDBITS-1:0] pend_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  sdp_be_write_merger_if #(.WABITS(WABITS), .NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH)) req ();

  sdp_be_write_merger #(
    .WABITS(WABITS), .NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .s(req.slave), .flush(flush), .ra(ra),
    .we(we), .wa(wa), .wd(wd), .be(be),
    .pend_hit(pend_hit), .pend_be(pend_be), .pend_data(pend_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WABITS-1:0] a, input logic [WDBITS-1:0] d,
                       input logic [NBYTES-1:0] b, input logic f);
    req.s_valid = v;
    req.s_addr  = a;
    req.s_data  = d;
    req.s_be    = b;
    flush       = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    ra  = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (req.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", req.s_ready); end
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", we); end
    end
    n_checks++; if ({wa, wd, be} !== '0) begin n_fail++; $display("FAIL reset_wport got %h/%h/%h want 0", wa, wd, be); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (we !== 1'b0 || busy !== 1'b0 || req.s_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_idle we=%0b busy=%0b ready=%0b want 0/0/1", we, busy, req.s_ready);
      end
    end
  endtask

  task automatic test_merge_flush();
    ra = 10'd5;
    drive(1'b1, 10'd5, 32'h1122_3344, 4'b0001, 1'b0);
    tick();
    n_checks++; if (busy !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL merge_load busy=%0b we=%0b want 1/0", busy, we); end
    drive(1'b1, 10'd5, 32'hAABB_CCDD, 4'b0100, 1'b0);
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL merge_nowrite we=%0b want 0", we); end
    n_checks++; if (pend_hit !== 1'b1 || pend_be !== 4'b0101) begin
      n_fail++; $display("FAIL merge_pend hit=%0b be=%b want 1/0101", pend_hit, pend_be);
    end
    n_checks++; if (pend_data[7:0] !== 8'h44 || pend_data[23:16] !== 8'hBB) begin
      n_fail++; $display("FAIL merge_pend_data got %h want lanes 0=44 2=BB", pend_data);
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    tick();
    n_checks++; if (we !== 1'b1 || wa !== 10'd5 || be !== 4'b0101) begin
      n_fail++; $display("FAIL merge_flush_write we=%0b wa=%0d be=%b want 1/5/0101", we, wa, be);
    end
    n_checks++; if (wd[7:0] !== 8'h44 || wd[23:16] !== 8'hBB) begin
      n_fail++; $display("FAIL merge_flush_data got %h want lanes 0=44 2=BB", wd);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL merge_flush_busy got %0b want 0", busy); end
    idle();
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL merge_single_pulse we=%0b want 0", we); end
  endtask

  task automatic test_back_to_back();
    logic [WDBITS-1:0] d5;
    d5 = WDBITS'($urandom);
    drive(1'b1, 10'd5, d5, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 10'd6, WDBITS'($urandom), 4'b0011, 1'b0);
    tick();
    idle();
    ra = 10'd6;
    #1;
    n_checks++; if (we !== 1'b1 || wa !== 10'd5 || be !== 4'b1111 || wd !== d5) begin
      n_fail++; $display("FAIL b2b_evict we=%0b wa=%0d be=%b wd=%h want 1/5/1111/%h", we, wa, be, wd, d5);
    end
    n_checks++; if (busy !== 1'b1 || pend_hit !== 1'b1 || pend_be !== 4'b0011) begin
      n_fail++; $display("FAIL b2b_pend6 busy=%0b hit=%0b be=%b want 1/1/0011", busy, pend_hit, pend_be);
    end
    ra = 10'd5;
    #1;
    n_checks++; if (pend_hit !== 1'b0 || pend_be !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_old_nohit hit=%0b be=%b want 0/0000", pend_hit, pend_be);
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    tick();
    idle();
    n_checks++; if (we !== 1'b1 || wa !== 10'd6 || be !== 4'b0011) begin
      n_fail++; $display("FAIL b2b_flush6 we=%0b wa=%0d be=%b want 1/6/0011", we, wa, be);
    end
    tick();
  endtask

  task automatic test_hold_timeout();
    drive(1'b1, 10'd9, 32'hDEAD_BEEF, 4'b1000, 1'b0);
    tick();
    idle();
    for (int k = 1; k <= MAX_HOLD; k++) begin
      tick();
      if (k < MAX_HOLD) begin
        n_checks++; if (we !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL hold_wait_%0d we=%0b busy=%0b want 0/1", k, we, busy);
        end
      end else begin
        n_checks++; if (we !== 1'b1 || wa !== 10'd9 || be !== 4'b1000 || wd[31:24] !== 8'hDE || busy !== 1'b0) begin
          n_fail++; $display("FAIL hold_evict we=%0b wa=%0d be=%b wd=%h busy=%0b want 1/9/1000/DE../0", we, wa, be, wd, busy);
        end
      end
    end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL hold_after we=%0b want 0", we); end
  endtask

  task automatic test_zero_be();
    drive(1'b1, 10'd7, 32'h0102_0304, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 10'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    ra = 10'd3;
    tick();
    idle();
    n_checks++; if (we !== 1'b0 || pend_hit !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_be_noop we=%0b hit=%0b busy=%0b want 0/0/1", we, pend_hit, busy);
    end
    // The zero-mask cycle counted as idle, so the timeout lands on the same edge as with no request at all.
    for (int k = 2; k <= MAX_HOLD; k++) begin
      tick();
      if (k < MAX_HOLD) begin
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL zero_be_wait_%0d we=%0b want 0", k, we); end
      end else begin
        n_checks++; if (we !== 1'b1 || wa !== 10'd7 || wd !== 32'h0102_0304) begin
          n_fail++; $display("FAIL zero_be_evict we=%0b wa=%0d wd=%h want 1/7/01020304", we, wa, wd);
        end
      end
    end
    tick();
  endtask

  task automatic test_flush_corner();
    drive(1'b0, '0, '0, '0, 1'b1);
    tick();
    idle();
    tick();
    n_checks++; if (we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_empty we=%0b busy=%0b want 0/0", we, busy); end
    drive(1'b1, 10'd10, 32'h0000_00AA, 4'b0001, 1'b0);
    tick();
    drive(1'b1, 10'd11, 32'h0000_BB00, 4'b0010, 1'b1);
    tick();
    idle();
    ra = 10'd11;
    #1;
    n_checks++; if (we !== 1'b1 || wa !== 10'd10 || be !== 4'b0001 || busy !== 1'b1 || pend_hit !== 1'b1) begin
      n_fail++; $display("FAIL flush_diff we=%0b wa=%0d be=%b busy=%0b hit=%0b want 1/10/0001/1/1", we, wa, be, busy, pend_hit);
    end
    drive(1'b1, 10'd11, 32'h00CC_0000, 4'b0100, 1'b1);
    tick();
    idle();
    n_checks++; if (we !== 1'b1 || wa !== 10'd11 || be !== 4'b0110 || wd[23:8] !== 16'hCCBB || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_same we=%0b wa=%0d be=%b wd=%h busy=%0b want 1/11/0110/..CCBB../0", we, wa, be, wd, busy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [WDBITS-1:0] ref_mem [0:7];
    logic [WDBITS-1:0] dut_img [0:7];
    logic [WDBITS-1:0] rd;
    logic              v, f;
    logic [2:0]        a;
    logic [WDBITS-1:0] d;
    logic [NBYTES-1:0] b;
    int                n_acc = 0;
    int                n_wr  = 0;
    for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; dut_img[i] = '0; end
    idle();
    for (int cyc = 0; cyc < 400 + 2; cyc++) begin
      tick();
      if (we === 1'b1) begin
        n_wr++;
        n_checks++; if (be === '0 || wa > 10'd7) begin
          n_fail++; $display("FAIL rand_write_legal wa=%0d be=%b want wa<8 be!=0", wa, be);
        end else begin
          for (int l = 0; l < NBYTES; l++)
            if (be[l]) dut_img[wa[2:0]][l*BYTEWIDTH +: BYTEWIDTH] = wd[l*BYTEWIDTH +: BYTEWIDTH];
        end
      end
      if (cyc < 400) begin
        v = ($urandom_range(9) < 6);
        a = 3'($urandom_range(7));
        d = WDBITS'($urandom);
        b = NBYTES'($urandom);
        f = ($urandom_range(9) == 0);
      end else begin
        v = 1'b0; a = '0; d = '0; b = '0; f = (cyc == 400);
      end
      drive(v, {7'd0, a}, d, b, f);
      ra = 10'($urandom_range(7));
      #1;
      // A read patched with the pending lanes must see every write accepted so far.
      rd = dut_img[ra[2:0]];
      for (int l = 0; l < NBYTES; l++)
        if (pend_be[l]) rd[l*BYTEWIDTH +: BYTEWIDTH] = pend_data[l*BYTEWIDTH +: BYTEWIDTH];
      n_checks++; if (rd !== ref_mem[ra[2:0]]) begin
        n_fail++; $display("FAIL rand_patched_read cyc=%0d ra=%0d got %h want %h", cyc, ra, rd, ref_mem[ra[2:0]]);
      end
      if (v && b != '0) begin
        n_acc++;
        for (int l = 0; l < NBYTES; l++)
          if (b[l]) ref_mem[a][l*BYTEWIDTH +: BYTEWIDTH] = d[l*BYTEWIDTH +: BYTEWIDTH];
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drained busy=%0b want 0", busy); end
    n_checks++; if (n_wr > n_acc) begin n_fail++; $display("FAIL rand_write_count writes=%0d accepts=%0d want writes<=accepts", n_wr, n_acc); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (dut_img[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL rand_final_mem addr=%0d got %h want %h", i, dut_img[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 10'd2, 32'h5555_5555, 4'b1111, 1'b0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (req.s_ready !== 1'b0 || we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_during ready=%0b we=%0b want 0/0", req.s_ready, we);
    end
    rst = 1'b0;
    ra  = 10'd2;
    for (int k = 0; k < MAX_HOLD + 4; k++) begin
      tick();
      n_checks++; if (we !== 1'b0 || pend_hit !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midrst_after_%0d we=%0b hit=%0b busy=%0b want 0/0/0", k, we, pend_hit, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ra  = '0;
    idle();
    test_reset();
    test_merge_flush();
    test_back_to_back();
    test_hold_timeout();
    test_zero_be();
    test_flush_corner();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
